pwm_capture: RTL and testbench

- Decodes an incoming PWM waveform back into an 8-bit duty value, the receive-side counterpart of the team's PWM generator.
- Measures the high time and the period of the input in clk cycles, then computes duty = floor(high*256/period) with a sequential divider.
- Reports the period and a one-cycle valid strobe, and detects a stuck or idle line by timeout.
- Used for loopback checking of PWM outputs and for reading external PWM sensors over the I2C register path.

---
 rtl/pwm_capture.sv | 148 ++++++++++++++
 tb/tb_pwm_capture.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM receiver: measures high time and period, divides to an 8-bit duty, flags a stuck line
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             pwm_in,
    output logic [7:0]       duty,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DIVIDE,
        DONE,
        TIMEOUT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] div_p;
    logic [CNT_W-1:0] rem;
    logic [7:0]       q;
    logic [2:0]       iter;
    logic             to_done;
    logic             timeout_hit;
    logic             load;
    logic [CNT_W:0]   rem_sh;
    logic             rem_ge;
    logic [CNT_W-1:0] rem_sub;

    assign rise        = s2 & ~s3;
    // to_done keeps a saturated per_cnt from re-firing the timeout until a new rise
    assign timeout_hit = (per_cnt == CNT_MAX) && !to_done;
    assign rem_sh      = {rem, 1'b0};
    assign rem_ge      = (rem_sh >= {1'b0, div_p});
    // true difference is below div_p, so the CNT_W-bit wrap-around result is exact
    assign rem_sub     = rem_sh[CNT_W-1:0] - div_p;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = ARMED;
                end else if (timeout_hit) begin
                    state_nxt = TIMEOUT;
                end
            end
            ARMED: begin
                if (rise) begin
                    load      = 1'b1;
                    state_nxt = DIVIDE;
                end else if (timeout_hit) begin
                    state_nxt = TIMEOUT;
                end
            end
            DIVIDE: begin
                if (iter == 3'd7) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = ARMED;
            TIMEOUT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            per_cnt  <= '0;
            high_cnt <= '0;
            div_p    <= '0;
            rem      <= '0;
            q        <= '0;
            iter     <= '0;
            to_done  <= 1'b0;
            duty     <= '0;
            period   <= '0;
            valid    <= 1'b0;
            stuck    <= 1'b0;
        end else begin
            state <= state_nxt;
            s1    <= pwm_in;
            s2    <= s1;
            s3    <= s2;
            valid <= 1'b0;

            if (rise) begin
                per_cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
                high_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                if (per_cnt != CNT_MAX) begin
                    per_cnt <= per_cnt + 1'b1;
                end
                if (s2 && (high_cnt != CNT_MAX)) begin
                    high_cnt <= high_cnt + 1'b1;
                end
            end

            if (state_nxt == TIMEOUT) begin
                to_done <= 1'b1;
            end else if (rise) begin
                to_done <= 1'b0;
            end

            if (load) begin
                div_p <= per_cnt;
                rem   <= high_cnt;
                q     <= '0;
                iter  <= '0;
            end else if (state == DIVIDE) begin
                rem  <= rem_ge ? rem_sub : rem_sh[CNT_W-1:0];
                q    <= {q[6:0], rem_ge};
                iter <= iter + 3'd1;
            end

            if (state == DONE) begin
                duty   <= q;
                period <= div_p;
                stuck  <= 1'b0;
                valid  <= 1'b1;
            end else if (state == TIMEOUT) begin
                duty   <= s2 ? 8'hFF : 8'h00;
                period <= '0;
                stuck  <= 1'b1;
                valid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed bench for pwm_capture at CNT_W=16 and CNT_W=8
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        n_rst16;
    logic        n_rst8;
    logic        pwm16;
    logic        pwm8;
    logic [7:0]  duty16;
    logic [15:0] period16;
    logic        valid16;
    logic        stuck16;
    logic [7:0]  duty8;
    logic [7:0]  period8;
    logic        valid8;
    logic        stuck8;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int nv16   = 0;
    int nv8    = 0;
    int mark16 = 0;
    int mark8  = 0;
    int lat16  = 0;
    int lat8   = 0;
    int d16    = 0;
    int p16    = 0;
    int s16    = 0;
    int d8     = 0;
    int p8     = 0;
    int s8     = 0;
    int n0     = 0;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(16)) u16 (
        .clk    (clk),
        .n_rst  (n_rst16),
        .pwm_in (pwm16),
        .duty   (duty16),
        .period (period16),
        .valid  (valid16),
        .stuck  (stuck16)
    );

    pwm_capture #(.CNT_W(8)) u8 (
        .clk    (clk),
        .n_rst  (n_rst8),
        .pwm_in (pwm8),
        .duty   (duty8),
        .period (period8),
        .valid  (valid8),
        .stuck  (stuck8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // one clock, sampled 1ns after the edge; latches the most recent strobe of each DUT
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (valid16) begin
            nv16++;
            d16   = duty16;
            p16   = period16;
            s16   = stuck16;
            lat16 = cyc - mark16;
        end
        if (valid8) begin
            nv8++;
            d8   = duty8;
            p8   = period8;
            s8   = stuck8;
            lat8 = cyc - mark8;
        end
    endtask

    task automatic wave(input bit sel8, input int p, input int h, input int n);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < p; c++) begin
                if (sel8) begin
                    pwm8 = (c < h);
                    if (c == 0) mark8 = cyc;
                end else begin
                    pwm16 = (c < h);
                    if (c == 0) mark16 = cyc;
                end
                tick();
            end
        end
    endtask

    initial begin
        n_rst16 = 1'b0;
        n_rst8  = 1'b0;
        pwm16   = 1'b0;
        pwm8    = 1'b0;
        repeat (3) tick();
        check("rst16_duty",   duty16,   0);
        check("rst16_period", period16, 0);
        check("rst16_valid",  valid16,  0);
        check("rst16_stuck",  stuck16,  0);
        check("rst8_duty",    duty8,    0);
        check("rst8_stuck",   stuck8,   0);

        n_rst16 = 1'b1;
        repeat (3) tick();
        wave(1'b0, 100, 25, 1);
        check("first_rise_novalid", nv16, 0);
        wave(1'b0, 100, 25, 1);
        check("p100_count",  nv16,  1);
        check("p100_duty",   d16,   64);
        check("p100_period", p16,   100);
        check("p100_stuck",  s16,   0);
        check("p100_lat",    lat16, 12);
        wave(1'b0, 100, 25, 3);
        check("p100_count3", nv16, 4);
        check("p100_duty3",  d16,  64);

        wave(1'b0, 256, 128, 3);
        check("p256_duty",   d16,   128);
        check("p256_period", p16,   256);
        check("p256_lat",    lat16, 12);
        wave(1'b0, 1000, 999, 2);
        check("h999_duty",   d16, 255);
        check("h999_period", p16, 1000);
        wave(1'b0, 1000, 1, 2);
        check("h1_duty",   d16, 0);
        check("h1_period", p16, 1000);

        // reset while the divider is mid-flight
        wave(1'b0, 100, 25, 2);
        check("pre_rst_duty", d16, 64);
        for (int c = 0; c < 5; c++) begin
            pwm16 = 1'b1;
            if (c == 0) mark16 = cyc;
            tick();
        end
        n0      = nv16;
        n_rst16 = 1'b0;
        pwm16   = 1'b0;
        tick();
        check("midrst_duty",   duty16,   0);
        check("midrst_period", period16, 0);
        check("midrst_valid",  valid16,  0);
        check("midrst_stuck",  stuck16,  0);
        n_rst16 = 1'b1;
        repeat (100) tick();
        check("midrst_nostrobe", nv16, n0);
        wave(1'b0, 100, 25, 1);
        check("postrst_first", nv16, n0);
        wave(1'b0, 100, 25, 1);
        check("postrst_count",  nv16,  n0 + 1);
        check("postrst_duty",   d16,   64);
        check("postrst_period", p16,   100);
        check("postrst_lat",    lat16, 12);

        // CNT_W=8 instance: timeout behaviour
        n_rst8 = 1'b1;
        repeat (3) tick();
        wave(1'b1, 100, 50, 3);
        check("w8_count",  nv8, 2);
        check("w8_duty",   d8,  128);
        check("w8_period", p8,  100);
        check("w8_stuck",  s8,  0);

        pwm8  = 1'b1;
        mark8 = cyc;
        repeat (20) tick();
        check("hi_meas_count", nv8, 3);
        n0 = nv8;
        repeat (380) tick();
        check("hi_to_count",  nv8,  n0 + 1);
        check("hi_to_duty",   d8,   255);
        check("hi_to_period", p8,   0);
        check("hi_to_stuck",  s8,   1);
        check("hi_to_lat",    lat8, 259);

        pwm8 = 1'b0;
        repeat (10) tick();
        n0 = nv8;
        wave(1'b1, 100, 50, 3);
        check("resume_count",  nv8, n0 + 2);
        check("resume_duty",   d8,  128);
        check("resume_stuck",  s8,  0);
        check("resume_period", p8,  100);

        pwm8 = 1'b0;
        n0   = nv8;
        repeat (300) tick();
        check("lo_to_count",  nv8,  n0 + 1);
        check("lo_to_duty",   d8,   0);
        check("lo_to_period", p8,   0);
        check("lo_to_stuck",  s8,   1);
        check("lo_to_lat",    lat8, 259);

        n0 = nv8;
        wave(1'b1, 100, 50, 1);
        check("lo_resume_first", nv8, n0);
        wave(1'b1, 100, 50, 1);
        check("lo_resume_count", nv8, n0 + 1);
        check("lo_resume_duty",  d8,  128);
        check("lo_resume_stuck", s8,  0);

        // P=8: every other rise lands in DIVIDE, so one strobe per 16 cycles
        wave(1'b1, 8, 3, 10);
        n0 = nv8;
        wave(1'b1, 8, 3, 20);
        check("p8_count",  nv8, n0 + 10);
        check("p8_duty",   d8,  96);
        check("p8_period", p8,  8);
        check("p8_stuck",  s8,  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
